// File: rtl/moving_average_pkg.sv
// moving_average_pkg
//   Shared constants and helpers for the moving-average filters.
//   - DEFAULT_DATA_WIDTH / DEFAULT_MAX_LOG2_WIN: default parameter values,
//     common to the fixed-mode filter and moving_average_window.
//   - sum_width(): width of a running sum that can never overflow.
//   - clamp_log2(): limits a requested window log2 to the largest window.
package moving_average_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_MAX_LOG2_WIN = 4;

    // 2^max_log2_win samples of data_width bits each sum without overflow
    // in data_width + max_log2_win bits.
    function automatic int sum_width(input int data_width, input int max_log2_win);
        return data_width + max_log2_win;
    endfunction

    function automatic int clamp_log2(input int req, input int max_log2_win);
        return (req > max_log2_win) ? max_log2_win : req;
    endfunction

endpackage

// File: rtl/ma_sample_ring.sv
// ma_sample_ring
//   Circular sample buffer of 2^MAX_LOG2_WIN entries. One write port at the
//   write pointer, one asynchronous read port at an address supplied by the
//   caller. Storage is not reset; only the write pointer is.
// Ports
//   clk, rst   : clock, asynchronous active-high reset (write pointer only)
//   we         : write wdata at wp and advance wp this cycle
//   wdata      : sample to store
//   rd_addr    : asynchronous read address
//   wp         : current write pointer, wraps modulo the depth
//   rd_data    : ring[rd_addr]; reflects contents before this cycle's write
module ma_sample_ring
    import moving_average_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MAX_LOG2_WIN = DEFAULT_MAX_LOG2_WIN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [MAX_LOG2_WIN-1:0] rd_addr,
    output logic [MAX_LOG2_WIN-1:0] wp,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int DEPTH = 1 << MAX_LOG2_WIN;

    logic [DATA_WIDTH-1:0] ring [DEPTH];

    assign rd_data = ring[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
        end else if (we) begin
            wp <= wp + MAX_LOG2_WIN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            ring[wp] <= wdata;
        end
    end

endmodule

// File: rtl/moving_average_window.sv
// moving_average_window
//   Exact boxcar average over a runtime-selectable window of 2^win_log2
//   samples (1 .. 2^MAX_LOG2_WIN), kept as a lossless running sum over a
//   circular sample buffer. One averaged sample per accepted input once the
//   window is full.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous restart of the fill (buffer contents kept)
//   win_log2   : requested window log2, clamped to MAX_LOG2_WIN
//   in_valid   : din is accepted this cycle (no backpressure)
//   din        : signed input sample
//   out_valid  : single-cycle strobe, dout is new
//   dout       : signed window average, floored toward -inf
//   full       : the active window holds 2^win_act samples
//
// Handshake: the producer asserts in_valid for exactly the cycles it has a
// sample; every such cycle consumes din (there is no ready). out_valid is a
// one-cycle strobe with no ready either; dout is held between strobes.
//
// Fill state is implicit in the fill counter: FILLING while fill < 2^win_act,
// FULL otherwise. Any restart (clear, or a change of the clamped window)
// drops back to FILLING; a sample accepted in the restart cycle is the first
// sample of the new window.
module moving_average_window
    import moving_average_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MAX_LOG2_WIN = DEFAULT_MAX_LOG2_WIN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic [$clog2(MAX_LOG2_WIN+1)-1:0]    win_log2,
    input  logic                                 in_valid,
    input  logic signed [DATA_WIDTH-1:0]         din,
    output logic                                 out_valid,
    output logic signed [DATA_WIDTH-1:0]         dout,
    output logic                                 full
);

    localparam int WL_W   = $clog2(MAX_LOG2_WIN + 1);
    localparam int SW     = sum_width(DATA_WIDTH, MAX_LOG2_WIN);
    localparam int AW     = MAX_LOG2_WIN;
    localparam int FILL_W = MAX_LOG2_WIN + 1;

    logic [WL_W-1:0]        win_act;
    logic signed [SW-1:0]   sum;
    logic [FILL_W-1:0]      fill;

    logic [WL_W-1:0]        win_req;
    logic                   restart;
    logic [FILL_W-1:0]      win_size;
    logic [FILL_W-1:0]      win_size_next;
    logic [AW-1:0]          wp;
    logic [AW-1:0]          rd_addr;
    logic [DATA_WIDTH-1:0]  old;
    logic signed [SW-1:0]   din_ext;
    logic signed [SW-1:0]   old_term;

    logic [WL_W-1:0]        win_next;
    logic signed [SW-1:0]   sum_next;
    logic [FILL_W-1:0]      fill_next;
    logic                   full_next;
    logic                   out_fire;
    logic signed [SW-1:0]   avg;

    // The sample leaving the window sits 2^win_act entries behind wp; the
    // subtraction is done one bit wider and truncated so it wraps modulo the
    // depth (a full-depth window reads the slot about to be overwritten).
    always_comb begin
        win_size = FILL_W'(1) << win_act;
        rd_addr  = AW'({1'b0, wp} - win_size);
    end

    ma_sample_ring #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MAX_LOG2_WIN (MAX_LOG2_WIN)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .we      (in_valid),
        .wdata   (din),
        .rd_addr (rd_addr),
        .wp      (wp),
        .rd_data (old)
    );

    always_comb begin
        win_req  = WL_W'(clamp_log2(int'(win_log2), MAX_LOG2_WIN));
        restart  = clear || (win_req != win_act);
        din_ext  = {{MAX_LOG2_WIN{din[DATA_WIDTH-1]}}, din};
        // Until the window is full nothing has aged out yet.
        old_term = full ? {{MAX_LOG2_WIN{old[DATA_WIDTH-1]}}, old} : '0;
    end

    always_comb begin
        win_next  = win_act;
        sum_next  = sum;
        fill_next = fill;
        if (restart) begin
            win_next = win_req;
            if (in_valid) begin
                sum_next  = din_ext;
                fill_next = FILL_W'(1);
            end else begin
                sum_next  = '0;
                fill_next = '0;
            end
        end else if (in_valid) begin
            sum_next  = sum + din_ext - old_term;
            fill_next = (fill == win_size) ? fill : fill + FILL_W'(1);
        end
        win_size_next = FILL_W'(1) << win_next;
        full_next     = (fill_next == win_size_next);
        out_fire      = in_valid && full_next;
        avg           = sum_next >>> win_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_act   <= '0;
            sum       <= '0;
            fill      <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            win_act   <= win_next;
            sum       <= sum_next;
            fill      <= fill_next;
            full      <= full_next;
            out_valid <= out_fire;
            // An average of in-range samples always fits in DATA_WIDTH.
            if (out_fire) begin
                dout <= DATA_WIDTH'(avg);
            end
        end
    end

endmodule

// File: tb/tb_moving_average_window.sv
// tb_moving_average_window
//   Directed vectors with hand-computed expectations for
//   moving_average_window (DATA_WIDTH=16, MAX_LOG2_WIN=4).
module tb_moving_average_window;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic [2:0]         win_log2 = 3'd0;
    logic               in_valid = 1'b0;
    logic signed [15:0] din = '0;
    logic               out_valid;
    logic signed [15:0] dout;
    logic               full;

    int n_cmp = 0;
    int n_err = 0;

    moving_average_window #(
        .DATA_WIDTH   (16),
        .MAX_LOG2_WIN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .win_log2  (win_log2),
        .in_valid  (in_valid),
        .din       (din),
        .out_valid (out_valid),
        .dout      (dout),
        .full      (full)
    );

    // clock
    always #5 clk = ~clk;

    // checker
    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver: one accepted sample, outputs checked #1 after the capturing edge
    task automatic send(input int d, input logic exp_v, input int exp_d,
                        input logic exp_full, input string tag);
        @(negedge clk);
        in_valid = 1'b1;
        din      = 16'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        check_eq({tag, ".out_valid"}, int'(out_valid), int'(exp_v));
        if (exp_v) check_eq({tag, ".dout"}, int'(dout), exp_d);
        check_eq({tag, ".full"}, int'(full), int'(exp_full));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.out_valid", int'(out_valid), 0);
        check_eq("reset.dout", int'(dout), 0);
        check_eq("reset.full", int'(full), 0);
        @(negedge clk);
        rst = 1'b0;

        // window 4: 4,8,12,16 -> 10, then 20 -> 14
        win_log2 = 3'd2;
        send(4,  1'b0, 0,  1'b0, "w2.s0");
        send(8,  1'b0, 0,  1'b0, "w2.s1");
        send(12, 1'b0, 0,  1'b0, "w2.s2");
        send(16, 1'b1, 10, 1'b1, "w2.s3");
        send(20, 1'b1, 14, 1'b1, "w2.s4");

        // window change in the same cycle as a sample: it starts the new window
        win_log2 = 3'd1;
        send(6, 1'b0, 0, 1'b0, "chg.s0");
        send(2, 1'b1, 4, 1'b1, "chg.s1");

        // clear with a sample; floor of -3.5 is -4
        clear = 1'b1;
        send(-3, 1'b0, 0,  1'b0, "neg.s0");
        send(-4, 1'b1, -4, 1'b1, "neg.s1");

        // window 1: registered pass-through at both extremes
        win_log2 = 3'd0;
        send(-32768, 1'b1, -32768, 1'b1, "w0.s0");
        send(32767,  1'b1, 32767,  1'b1, "w0.s1");
        idle_cycle();
        check_eq("w0.idle.out_valid", int'(out_valid), 0);
        check_eq("w0.idle.dout", int'(dout), 32767);
        check_eq("w0.idle.full", int'(full), 1);

        // win_log2=7 clamps to 16 samples
        win_log2 = 3'd7;
        for (int k = 1; k <= 15; k++)
            send(32767, 1'b0, 0, 1'b0, $sformatf("clamp.s%0d", k));
        send(32767, 1'b1, 32767, 1'b1, "clamp.s16");

        // 7 -> 4 is the same clamped window: no restart. Descend to -32768
        // with wp wrapping cleanly.
        win_log2 = 3'd4;
        for (int k = 1; k <= 16; k++) begin
            e = (16 * 32767 - k * 65535) >>> 4;
            send(-32768, 1'b1, e, 1'b1, $sformatf("desc.s%0d", k));
        end

        // clear on an idle cycle empties the window
        win_log2 = 3'd1;
        send(10, 1'b0, 0,  1'b0, "clr.s0");
        send(20, 1'b1, 15, 1'b1, "clr.s1");
        clear = 1'b1;
        idle_cycle();
        clear = 1'b0;
        check_eq("clr.idle.out_valid", int'(out_valid), 0);
        check_eq("clr.idle.full", int'(full), 0);
        send(1, 1'b0, 0, 1'b0, "clr.s2");
        send(2, 1'b1, 1, 1'b1, "clr.s3");

        // asynchronous reset mid-fill of an 8-sample window
        win_log2 = 3'd3;
        send(5, 1'b0, 0, 1'b0, "rst.s0");
        send(6, 1'b0, 0, 1'b0, "rst.s1");
        send(7, 1'b0, 0, 1'b0, "rst.s2");
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst.async.dout", int'(dout), 0);
        check_eq("rst.async.out_valid", int'(out_valid), 0);
        check_eq("rst.async.full", int'(full), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++)
            send(k, 1'b0, 0, 1'b0, $sformatf("post.s%0d", k));
        send(8, 1'b1, 4, 1'b1, "post.s8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
